regfile_read_port: RTL and testbench
====================================

# regfile_read_port

Operand read stage that sits on the output side of the 16 x 16-bit register file. It selects two registers (or a register and an immediate) from the file's r0..r15 outputs and registers them as ALU operands. Write data on the ALU bus is forwarded so no captured or held operand is ever stale. A valid/ready handshake lets the ALU stall the stage.

## Interface
Parameters:
- WIDTH, 16, data width of registers, bus and operands
- NREGS, 16, number of registers; index width is log2(NREGS) = 4

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- r0 .. r15  in  WIDTH each  current register file contents
- regEn  in  NREGS  per-register write enables of the file, one bit per register
- aluBus  in  WIDTH  data the file writes this cycle
- srcSel  in  4  source register index (operand B)
- dstSel  in  4  destination register index (operand A)
- immVal  in  WIDTH  immediate value
- useImm  in  1  1: operand B = immVal instead of r[srcSel]
- inValid  in  1  a read request is present
- inReady  out  1  stage can accept a request this cycle
- opA  out  WIDTH  registered operand A
- opB  out  WIDTH  registered operand B
- dstIdx  out  4  registered dstSel, used for writeback
- outValid  out  1  opA/opB/dstIdx hold a valid request
- outReady  in  1  ALU consumes the operands this cycle

## Operation
- Two states: EMPTY (outValid = 0) and FULL (outValid = 1).
- inReady = !outValid || outReady. This is combinational and has no dependence on inValid.
- Accept = inValid && inReady. On accept:
  - opA <= fwd(dstSel).
  - opB <= useImm ? immVal : fwd(srcSel).
  - dstIdx <= dstSel.
  - outValid <= 1.
- fwd(i) = regEn[i] ? aluBus : r[i]. A same-cycle write wins over the file's pre-edge value.
- Consume = outValid && outReady. Consume without accept sets outValid <= 0. Consume and accept in the same cycle keeps outValid = 1 and loads the new request.
- Hold (FULL, no consume):
  - opA/opB/dstIdx keep their request.
  - When regEn[dstIdx] = 1, opA <= aluBus.
  - When regEn[held src index] = 1 and the held request is not immediate, opB <= aluBus.
  - To support this, the stage stores the src index and the useImm flag internally.
- regEn is not required to be one-hot. Each bit is evaluated independently, and all enabled registers receive the same aluBus value.
- srcSel == dstSel is legal. Both operands then read the same (forwarded) value.
- Indices are always in range (4 bits, 16 registers). No wrap logic is required.

## Timing
- Reset, checked at the clk edge while reset = 0:
  - outValid = 0, opA = 0, opB = 0, dstIdx = 0, internal src index = 0, useImm flag = 0.
  - inReady reads 1 after reset.
- Reset wins over accept, consume and forwarding in the same cycle. A request in flight is dropped.
- Latency: a request accepted at edge N has outValid = 1 and operands visible after edge N.
- Throughput: 1 request per cycle while outReady = 1.
- Back-pressure: while outValid = 1 and outReady = 0, inReady = 0 and outputs are stable, except for the forwarding updates described in Operation.
- opA/opB change only at clk edges. There is no combinational path from r0..r15 to the outputs.

## Test plan
- Reset: drive reset = 0 for 2 cycles, then 1. Required: outValid = 0, opA = opB = 0, dstIdx = 0, inReady = 1.
- Basic read: r3 = 16'h153a, r8 = 16'h2222, dstSel = 3, srcSel = 8, useImm = 0, inValid = 1, outReady = 1. Required, one cycle later: opA = 16'h153a, opB = 16'h2222, dstIdx = 3, outValid = 1.
- Forwarding on accept: r0 = 16'h1111, regEn = 16'h0001, aluBus = 16'h3333, dstSel = srcSel = 0, accept. Required: opA = opB = 16'h3333.
- Stall with writeback: accept dstSel = 14, srcSel = 2, useImm = 0, then hold outReady = 0. Drive regEn = 16'h4004 and aluBus = 16'h5555 for one cycle. Required:
  - inReady = 0 during the stall.
  - opA = opB = 16'h5555 after that edge.
  - outValid stays 1 until outReady = 1.
- Immediate and back-to-back: issue three requests on consecutive cycles with outReady = 1:
  - immVal = 16'h0007, useImm = 1, srcSel = 5, with regEn[5] = 1. Required: opB = 16'h0007, not aluBus.
  - Two further register reads. Required: one result per cycle and no bubbles.
- Reset mid-operation: while FULL and stalled, pulse reset = 0 for one cycle. Required: outValid = 0 and opA = opB = 0 on the next cycle, with no later emission of the dropped request.

Source files
------------

// File: rtl/regfile_read_port.sv
// regfile_read_port: operand read stage with write-bus forwarding and a valid/ready handshake
module regfile_read_port #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 16,
    localparam int IW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    input  logic [WIDTH-1:0] r4,
    input  logic [WIDTH-1:0] r5,
    input  logic [WIDTH-1:0] r6,
    input  logic [WIDTH-1:0] r7,
    input  logic [WIDTH-1:0] r8,
    input  logic [WIDTH-1:0] r9,
    input  logic [WIDTH-1:0] r10,
    input  logic [WIDTH-1:0] r11,
    input  logic [WIDTH-1:0] r12,
    input  logic [WIDTH-1:0] r13,
    input  logic [WIDTH-1:0] r14,
    input  logic [WIDTH-1:0] r15,
    input  logic [NREGS-1:0] regEn,
    input  logic [WIDTH-1:0] aluBus,
    input  logic [IW-1:0]    srcSel,
    input  logic [IW-1:0]    dstSel,
    input  logic [WIDTH-1:0] immVal,
    input  logic             useImm,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic [IW-1:0]    dstIdx,
    output logic             outValid,
    input  logic             outReady
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [IW-1:0]    r_dst;
    logic [IW-1:0]    r_src;
    logic             r_imm;
    logic [WIDTH-1:0] w_regs [NREGS];
    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic             w_accept;
    logic             w_consume;
    logic             w_hold;

    assign w_regs    = '{r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15};
    assign w_fwd_a   = regEn[dstSel] ? aluBus : w_regs[dstSel];
    assign w_fwd_b   = useImm ? immVal : regEn[srcSel] ? aluBus : w_regs[srcSel];
    assign outValid  = (r_state == FULL);
    assign inReady   = !outValid || outReady;
    assign w_accept  = inValid && inReady;
    assign w_consume = outValid && outReady;
    assign w_hold    = outValid && !outReady;
    assign opA       = r_opa;
    assign opB       = r_opb;
    assign dstIdx    = r_dst;

    // Next state: a new request fills the stage, a consume alone drains it
    always_comb begin
        w_next = w_accept ? FULL : w_consume ? EMPTY : r_state;
    end

    // State and operand registers; held operands track same-cycle writebacks
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_opa   <= '0;
            r_opb   <= '0;
            r_dst   <= '0;
            r_src   <= '0;
            r_imm   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_opa <= w_fwd_a;
                r_opb <= w_fwd_b;
                r_dst <= dstSel;
                r_src <= srcSel;
                r_imm <= useImm;
            end else if (w_hold) begin
                if (regEn[r_dst]) r_opa <= aluBus;
                if (!r_imm && regEn[r_src]) r_opb <= aluBus;
            end
        end
    end
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed and randomized checks against a register-file-level model
module tb_regfile_read_port;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rf [16];
    logic [15:0] regEn;
    logic [15:0] aluBus;
    logic [3:0]  srcSel;
    logic [3:0]  dstSel;
    logic [15:0] immVal;
    logic        useImm;
    logic        inValid;
    logic        inReady;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [3:0]  dstIdx;
    logic        outValid;
    logic        outReady;

    int n_chk = 0;
    int n_err = 0;

    // model: the request currently owned by the stage; operands are always the
    // freshest register-file contents, so they are looked up in rf when checked
    logic        m_valid;
    logic [3:0]  m_dst;
    logic [3:0]  m_src;
    logic        m_imm;
    logic [15:0] m_immv;
    logic        m_rst;

    always #5 clk = ~clk;

    regfile_read_port dut (
        .clk(clk), .reset(reset),
        .r0(rf[0]), .r1(rf[1]), .r2(rf[2]), .r3(rf[3]),
        .r4(rf[4]), .r5(rf[5]), .r6(rf[6]), .r7(rf[7]),
        .r8(rf[8]), .r9(rf[9]), .r10(rf[10]), .r11(rf[11]),
        .r12(rf[12]), .r13(rf[13]), .r14(rf[14]), .r15(rf[15]),
        .regEn(regEn), .aluBus(aluBus), .srcSel(srcSel), .dstSel(dstSel),
        .immVal(immVal), .useImm(useImm), .inValid(inValid), .inReady(inReady),
        .opA(opA), .opB(opB), .dstIdx(dstIdx), .outValid(outValid), .outReady(outReady)
    );

    // advance one clock: the file and the model absorb the inputs present at the edge
    task automatic step();
        logic acc, cons;
        acc   = inValid && (!m_valid || outReady);
        cons  = m_valid && outReady;
        m_rst = !reset;
        @(posedge clk);
        #1;
        if (m_rst) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_dst   = dstSel;
            m_src   = srcSel;
            m_imm   = useImm;
            m_immv  = immVal;
        end else if (cons) m_valid = 1'b0;
        for (int i = 0; i < 16; i++) if (regEn[i]) rf[i] = aluBus;
    endtask

    task automatic idle_inputs();
        regEn = '0; aluBus = '0; srcSel = '0; dstSel = '0;
        immVal = '0; useImm = 1'b0; inValid = 1'b0; outReady = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        m_valid = 1'b0; m_dst = '0; m_src = '0; m_imm = 1'b0; m_immv = '0;
        idle_inputs();
        reset = 1'b0;
        inValid = 1'b1; dstSel = 4'd5; srcSel = 4'd6;
        step();
        step();
        n_chk += 4;
        if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid got %b exp 0", outValid); end
        if (opA !== 16'h0) begin n_err++; $display("FAIL reset_opA got %h exp 0000", opA); end
        if (opB !== 16'h0) begin n_err++; $display("FAIL reset_opB got %h exp 0000", opB); end
        if (dstIdx !== 4'h0) begin n_err++; $display("FAIL reset_dstIdx got %h exp 0", dstIdx); end
        idle_inputs();
        reset = 1'b1;
        #1;
        n_chk++;
        if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_inReady got %b exp 1", inReady); end
    endtask

    task automatic test_basic();
        rf[3] = 16'h153a; rf[8] = 16'h2222;
        dstSel = 4'd3; srcSel = 4'd8; useImm = 1'b0; inValid = 1'b1; outReady = 1'b1;
        step();
        n_chk += 4;
        if (opA !== 16'h153a) begin n_err++; $display("FAIL basic_opA got %h exp 153a", opA); end
        if (opB !== 16'h2222) begin n_err++; $display("FAIL basic_opB got %h exp 2222", opB); end
        if (dstIdx !== 4'd3) begin n_err++; $display("FAIL basic_dstIdx got %h exp 3", dstIdx); end
        if (outValid !== 1'b1) begin n_err++; $display("FAIL basic_outValid got %b exp 1", outValid); end
        inValid = 1'b0;
        step();
        n_chk++;
        if (outValid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b exp 0", outValid); end
    endtask

    task automatic test_fwd_accept();
        rf[0] = 16'h1111;
        regEn = 16'h0001; aluBus = 16'h3333; dstSel = 4'd0; srcSel = 4'd0;
        useImm = 1'b0; inValid = 1'b1; outReady = 1'b1;
        step();
        n_chk += 2;
        if (opA !== 16'h3333) begin n_err++; $display("FAIL fwd_opA got %h exp 3333", opA); end
        if (opB !== 16'h3333) begin n_err++; $display("FAIL fwd_opB got %h exp 3333", opB); end
        idle_inputs();
        step();
    endtask

    task automatic test_stall();
        rf[14] = 16'haaaa; rf[2] = 16'hbbbb;
        dstSel = 4'd14; srcSel = 4'd2; useImm = 1'b0; inValid = 1'b1; outReady = 1'b1;
        step();
        dstSel = 4'd9; srcSel = 4'd9; outReady = 1'b0;
        regEn = 16'h4004; aluBus = 16'h5555;
        #1;
        n_chk++;
        if (inReady !== 1'b0) begin n_err++; $display("FAIL stall_inReady got %b exp 0", inReady); end
        step();
        n_chk += 4;
        if (opA !== 16'h5555) begin n_err++; $display("FAIL stall_opA got %h exp 5555", opA); end
        if (opB !== 16'h5555) begin n_err++; $display("FAIL stall_opB got %h exp 5555", opB); end
        if (dstIdx !== 4'd14) begin n_err++; $display("FAIL stall_dstIdx got %h exp e", dstIdx); end
        if (outValid !== 1'b1) begin n_err++; $display("FAIL stall_outValid got %b exp 1", outValid); end
        regEn = '0; aluBus = 16'h0bad;
        step();
        n_chk += 3;
        if (outValid !== 1'b1) begin n_err++; $display("FAIL stall_keep got %b exp 1", outValid); end
        if (opA !== 16'h5555) begin n_err++; $display("FAIL stall_hold_opA got %h exp 5555", opA); end
        if (inReady !== 1'b0) begin n_err++; $display("FAIL stall_inReady2 got %b exp 0", inReady); end
        inValid = 1'b0; outReady = 1'b1;
        step();
        n_chk++;
        if (outValid !== 1'b0) begin n_err++; $display("FAIL stall_release got %b exp 0", outValid); end
    endtask

    task automatic test_back_to_back();
        rf[1] = 16'h0101; rf[4] = 16'h0404; rf[6] = 16'h0606; rf[7] = 16'h0707; rf[9] = 16'h0909;
        outReady = 1'b1; inValid = 1'b1;
        dstSel = 4'd1; srcSel = 4'd5; immVal = 16'h0007; useImm = 1'b1;
        regEn = 16'h0020; aluBus = 16'h9999;
        step();
        n_chk += 3;
        if (opB !== 16'h0007) begin n_err++; $display("FAIL b2b_imm_opB got %h exp 0007", opB); end
        if (opA !== 16'h0101) begin n_err++; $display("FAIL b2b_imm_opA got %h exp 0101", opA); end
        if (outValid !== 1'b1) begin n_err++; $display("FAIL b2b_v1 got %b exp 1", outValid); end
        regEn = '0; useImm = 1'b0; dstSel = 4'd4; srcSel = 4'd6;
        step();
        n_chk += 4;
        if (outValid !== 1'b1) begin n_err++; $display("FAIL b2b_v2 got %b exp 1", outValid); end
        if (opA !== 16'h0404) begin n_err++; $display("FAIL b2b_opA2 got %h exp 0404", opA); end
        if (opB !== 16'h0606) begin n_err++; $display("FAIL b2b_opB2 got %h exp 0606", opB); end
        if (dstIdx !== 4'd4) begin n_err++; $display("FAIL b2b_dst2 got %h exp 4", dstIdx); end
        dstSel = 4'd7; srcSel = 4'd9;
        step();
        n_chk += 4;
        if (outValid !== 1'b1) begin n_err++; $display("FAIL b2b_v3 got %b exp 1", outValid); end
        if (opA !== 16'h0707) begin n_err++; $display("FAIL b2b_opA3 got %h exp 0707", opA); end
        if (opB !== 16'h0909) begin n_err++; $display("FAIL b2b_opB3 got %h exp 0909", opB); end
        if (dstIdx !== 4'd7) begin n_err++; $display("FAIL b2b_dst3 got %h exp 7", dstIdx); end
        inValid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        dstSel = 4'd10; srcSel = 4'd11; useImm = 1'b0; inValid = 1'b1; outReady = 1'b1;
        step();
        inValid = 1'b0; outReady = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_chk += 4;
        if (outValid !== 1'b0) begin n_err++; $display("FAIL rmid_outValid got %b exp 0", outValid); end
        if (opA !== 16'h0) begin n_err++; $display("FAIL rmid_opA got %h exp 0000", opA); end
        if (opB !== 16'h0) begin n_err++; $display("FAIL rmid_opB got %h exp 0000", opB); end
        if (dstIdx !== 4'h0) begin n_err++; $display("FAIL rmid_dstIdx got %h exp 0", dstIdx); end
        reset = 1'b1; outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if (outValid !== 1'b0) begin n_err++; $display("FAIL rmid_ghost%0d got %b exp 0", k, outValid); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 39) != 0);
            inValid  = 1'($urandom);
            outReady = ($urandom_range(0, 2) != 0);
            regEn    = 16'($urandom & $urandom & $urandom);
            aluBus   = 16'($urandom);
            srcSel   = 4'($urandom);
            dstSel   = ($urandom_range(0, 4) == 0) ? srcSel : 4'($urandom);
            immVal   = 16'($urandom);
            useImm   = 1'($urandom);
            #1;
            n_chk++;
            if (inReady !== (!m_valid || outReady)) begin
                n_err++; $display("FAIL rnd_inReady cyc %0d got %b exp %b", k, inReady, !m_valid || outReady);
            end
            step();
            n_chk++;
            if (outValid !== m_valid) begin n_err++; $display("FAIL rnd_outValid cyc %0d got %b exp %b", k, outValid, m_valid); end
            if (m_rst) begin
                n_chk++;
                if ({opA, opB, dstIdx} !== 36'h0) begin
                    n_err++; $display("FAIL rnd_reset cyc %0d got %h/%h/%h exp 0", k, opA, opB, dstIdx);
                end
            end else if (m_valid) begin
                n_chk += 3;
                if (opA !== rf[m_dst]) begin n_err++; $display("FAIL rnd_opA cyc %0d got %h exp %h", k, opA, rf[m_dst]); end
                if (opB !== (m_imm ? m_immv : rf[m_src])) begin
                    n_err++; $display("FAIL rnd_opB cyc %0d got %h exp %h", k, opB, m_imm ? m_immv : rf[m_src]);
                end
                if (dstIdx !== m_dst) begin n_err++; $display("FAIL rnd_dstIdx cyc %0d got %h exp %h", k, dstIdx, m_dst); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fwd_accept();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
